// File: rtl/dcache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dcache_pkg;

  localparam int OFFSET_W   = 5;
  localparam int INDEX_W    = 4;
  localparam int TAG_W      = 23;
  localparam int WORD_SEL_W = 3;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache, one entry per line.
// Latency: asynchronous read, writes land at the clock edge.
// Backpressure: none; the controller never issues a word and line write together.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES     = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [INDEX_W-1:0]    idx_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [TAG_W-1:0]      rd_tag_o,
  output logic [LINE_BITS-1:0]  rd_line_o,
  input  logic                  word_we_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [WORD_W-1:0]     word_dat_i,
  input  logic                  line_we_i,
  input  logic [TAG_W-1:0]      line_tag_i,
  input  logic [LINE_BITS-1:0]  line_dat_i
);

  logic [LINES-1:0]     valid_q, valid_d;
  logic [LINES-1:0]     dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [TAG_W-1:0]     tag_d  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];
  logic [LINE_BITS-1:0] data_d [LINES];

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_line_o  = data_q[idx_i];

  // Next-state of the arrays: a refill replaces the whole line and cleans it,
  // a store hit patches one word and marks the line dirty.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (line_we_i) begin
      valid_d[idx_i] = 1'b1;
      dirty_d[idx_i] = 1'b0;
      tag_d[idx_i]   = line_tag_i;
      data_d[idx_i]  = line_dat_i;
    end else if (word_we_i) begin
      dirty_d[idx_i] = 1'b1;
      data_d[idx_i][{word_sel_i, 5'b0} +: WORD_W] = word_dat_i;
    end
  end

  // Status bits are cleared by reset so every line misses afterwards.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid gates their use.
  always_ff @(posedge clk_i) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate direct-mapped D-cache controller at the MEM stage.
// Latency: hits complete in the request cycle; misses stall through writeback/refill.
// Backpressure: cpu_stall_o freezes the pipeline; memory uses one-outstanding enable/ack.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES     = 16,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_write_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [WORD_W-1:0]    cpu_data_i,
  output logic [WORD_W-1:0]    cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_idx;
  logic [WORD_SEL_W-1:0] req_word;
  logic                  unused_byte_bits;

  assign req_tag          = cpu_addr_i[OFFSET_W+INDEX_W +: TAG_W];
  assign req_idx          = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign req_word         = cpu_addr_i[2 +: WORD_SEL_W];
  assign unused_byte_bits = ^cpu_addr_i[1:0];

  logic                 rd_valid;
  logic                 rd_dirty;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_line;
  logic                 hit;
  logic                 word_we;
  logic                 line_we;

  state_e state_q, state_d;

  dcache_sram #(
    .LINES     (LINES),
    .LINE_BITS (LINE_BITS)
  ) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .idx_i      (req_idx),
    .rd_valid_o (rd_valid),
    .rd_dirty_o (rd_dirty),
    .rd_tag_o   (rd_tag),
    .rd_line_o  (rd_line),
    .word_we_i  (word_we),
    .word_sel_i (req_word),
    .word_dat_i (cpu_data_i),
    .line_we_i  (line_we),
    .line_tag_i (req_tag),
    .line_dat_i (mem_data_i)
  );

  assign hit = rd_valid && (rd_tag == req_tag);

  // FSM next-state and all outputs; the victim is read from the same index the
  // request addresses, which the stalled pipeline holds steady.
  always_comb begin
    state_d      = state_q;
    cpu_data_o   = '0;
    cpu_stall_o  = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    word_we      = 1'b0;
    line_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            if (cpu_write_i) begin
              word_we = 1'b1;
            end else begin
              cpu_data_o = rd_line[{req_word, 5'b0} +: WORD_W];
            end
          end else begin
            cpu_stall_o = 1'b1;
            state_d     = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {rd_tag, req_idx, {OFFSET_W{1'b0}}};
        mem_data_o   = rd_line;
        if (mem_ack_i) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        cpu_stall_o  = 1'b1;
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, req_idx, {OFFSET_W{1'b0}}};
        if (mem_ack_i) begin
          line_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any outstanding memory request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data-cache controller sitting at the MEM stage, downstream of the EX/MEM pipeline register. It answers the load/store requests that EX/MEM presents and generates the stall that freezes EX/MEM and earlier stages until the access completes. On a miss it writes back a dirty victim line, then refills from off-chip data memory over a one-outstanding-request enable/ack handshake.

## Interface
- LINES, 16: number of cache lines (power of 2)
- LINE_BITS, 256: line width (32 bytes, 8 words)
- ADDR_W, 32: byte-address width
- clk_i  in  1: clock
- rst_i  in  1: asynchronous, active-low reset
- cpu_req_i  in  1: MemRead | MemWrite from EX/MEM
- cpu_write_i  in  1: 1 = store, 0 = load
- cpu_addr_i  in  32: byte address (ALU result)
- cpu_data_i  in  32: store data
- cpu_data_o  out  32: load data, valid when cpu_req_i & ~cpu_write_i & ~cpu_stall_o
- cpu_stall_o  out  1: Mem_stall to pipeline registers and PC
- mem_enable_o  out  1: memory request valid
- mem_write_o  out  1: 1 = line write, 0 = line read
- mem_addr_o  out  32: line-aligned address, bits [4:0] = 0
- mem_data_o  out  256: write-back line
- mem_data_i  in  256: refill line
- mem_ack_i  in  1: one-cycle completion pulse

## Operation
- Address split: offset [4:0], word select [4:2], index [8:5], tag [31:9] (23 bits).
- Per-line state: valid, dirty, tag, and 256-bit data.
- Hit means `valid[index] & tag[index] == addr tag`.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - No request: stall 0, mem_enable 0.
  - Hit: stall 0.
    - Load: cpu_data_o is the selected word, combinational.
    - Store: at the clock edge, write cpu_data_i into the selected word and set dirty.
  - Miss: stall 1 combinationally in the same cycle.
    - Victim valid & dirty: go to WRITEBACK.
    - Otherwise: go to ALLOCATE.
- WRITEBACK:
  - Drive mem_enable=1, mem_write=1, mem_addr={victim tag, index, 5'b0}, mem_data_o=victim line.
  - Hold all of these until mem_ack_i, then go to ALLOCATE.
- ALLOCATE:
  - Drive mem_enable=1, mem_write=0, mem_addr={req tag, index, 5'b0}.
  - On mem_ack_i, write mem_data_i into the line, set valid=1, dirty=0, tag=req tag, and return to IDLE.
- After refill, the access hits in IDLE; a pending store merges and sets dirty at that edge.
- cpu_stall_o is 1 in WRITEBACK and ALLOCATE regardless of inputs.
- CPU inputs are held stable by the stalled EX/MEM register for as long as stall=1.
- mem_ack_i is ignored in IDLE.

## Timing
- Reset (rst_i low, any cycle including mid-refill):
  - state=IDLE; all valid and dirty bits cleared.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - cpu_stall_o follows cpu_req_i, because every access misses after reset.
  - cpu_data_o=0 whenever there is no load hit.
  - Tag and data arrays are not reset.
- Hit latency: 0 extra cycles; stall is never asserted.
- Clean miss, cycle 0 = request presented:
  - Cycle 0: stall=1.
  - Cycle 1: mem_enable=1.
  - Ack arrives at cycle A; the line is written at the A edge.
  - Cycle A+1: IDLE, hit, stall=0.
- Dirty miss: the WRITEBACK ack at cycle W is followed by ALLOCATE starting at cycle W+1; otherwise as for a clean miss.
- An ack that arrives in the first cycle of a state is legal, giving minimum miss penalty = 2 stall cycles (clean) or 3 (dirty).
- mem_enable_o drops in the cycle after the ack, or it stays high for WRITEBACK→ALLOCATE with mem_write_o switching to 0.
- Store to the line being refilled: the refill data is written first, and the store merges in the following IDLE cycle. The store is never lost.

## Structure
- Package dcache_pkg:
  - state enum {IDLE, WRITEBACK, ALLOCATE}
  - OFFSET_W=5, INDEX_W=4, TAG_W=23, WORD_SEL_W=3 localparams
- Sub-module dcache_sram:
  - Holds the tag/valid/dirty/data arrays.
  - Asynchronous read, synchronous write with a per-word write enable, plus full-line write for refill.
  - Clears valid/dirty on rst_i.
- The controller holds the FSM, hit logic and the mux.

## Test plan
- Reset, then load 0x0000_0040 with memory line = word i holding 0x1000+i:
  - stall=1 until ack; refill; stall=0 the next cycle; cpu_data_o=0x1000.
- Load 0x0000_0044 right after:
  - hit, stall=0 with no stall cycle, data=0x1001.
- Store 0xDEADBEEF to 0x0000_0048 (hit), then load 0x0000_0048:
  - returns 0xDEADBEEF; dirty[2]=1.
- Load 0x0000_0240 (same index 2, different tag):
  - WRITEBACK with mem_addr=0x0000_0040, mem_write=1, word 2 = 0xDEADBEEF in mem_data_o.
  - ALLOCATE with mem_addr=0x0000_0240, mem_write=0.
  - Stall ends one cycle after the second ack.
- Ack delayed 7 cycles, and mem_ack_i pulsed while in IDLE:
  - mem signals are held steady throughout the wait.
  - The stray IDLE ack causes no state change.
- Assert rst_i low during ALLOCATE:
  - mem_enable_o=0 immediately; line invalid.
  - The re-issued load misses again and refills correctly.
